// File: rtl/arp_responder.sv
// arp_responder: answers ARP requests for MY_IP with a 60-byte reply streamed in N-bit beats
module arp_responder #(
  parameter int N = 2,
  parameter logic [31:0] MY_IP = 32'h12_12_6b_0d
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [47:0]  mac,
  input  logic         rx_axiiv,
  input  logic [N-1:0] rx_axiid,
  input  logic         rx_frame_done,
  input  logic         rx_fcs_ok,
  output logic         tx_req,
  input  logic         tx_grant,
  output logic         tx_axiov,
  output logic [N-1:0] tx_axiod,
  output logic         tx_last,
  output logic [15:0]  replies_sent
);
  localparam int BPB = 8 / N;
  localparam int SW = BPB > 1 ? $clog2(BPB) : 1;
  localparam int BEATS = 480 / N;
  localparam logic [79:0] HDR = 80'h0806_0001_0800_06_04_0001;
  typedef enum logic [2:0] {IDLE, PARSE, DROP, PENDING, SEND} state_t;
  state_t state, state_n;
  logic [SW-1:0] sub;
  logic [5:0] idx;
  logic [7:0] sr, bv;
  logic bc, uc, nbc, nuc, rx_on, done, bad, hit;
  logic [47:0] req_sha;
  logic [31:0] req_spa;
  logic [8:0] tx_cnt;
  logic [479:0] frame;
  assign frame = {req_sha, mac, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
                  mac, MY_IP, req_sha, req_spa, 144'h0};
  assign tx_req = state == PENDING;
  assign tx_axiov = state == SEND;
  assign tx_axiod = tx_axiov ? N'(frame >> (480 - N * (int'(tx_cnt) + 1))) : '0;
  assign tx_last = tx_axiov && tx_cnt == 9'(BEATS - 1);
  // idx counts completed bytes, so a check fires on the beat that finishes byte idx
  always_comb begin
    rx_on = rx_axiiv && (state == IDLE || state == PARSE);
    bv = 8'({sr, rx_axiid});
    done = rx_on && sub == SW'(BPB - 1);
    nbc = bc && bv == 8'hff;
    nuc = uc && bv == 8'(mac >> (8 * (5 - int'(idx))));
    bad = done && ((idx == 6'd5 && !(nbc || nuc)) ||
                   (idx >= 6'd12 && idx <= 6'd21 && bv != 8'(HDR >> (8 * (21 - int'(idx))))) ||
                   (idx >= 6'd38 && idx <= 6'd41 && bv != 8'(MY_IP >> (8 * (41 - int'(idx))))));
    hit = rx_fcs_ok && idx >= 6'd42;
    state_n = state;
    case (state)
      IDLE:    state_n = rx_axiiv ? (bad ? DROP : PARSE) : IDLE;
      PARSE:   state_n = rx_frame_done ? (hit ? PENDING : IDLE) : (bad ? DROP : PARSE);
      DROP:    state_n = rx_frame_done ? IDLE : DROP;
      PENDING: state_n = tx_grant ? SEND : PENDING;
      SEND:    state_n = tx_last ? IDLE : SEND;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
    tx_cnt <= (rst || state != SEND) ? '0 : tx_cnt + 9'd1;
    replies_sent <= rst ? '0 : replies_sent + 16'(tx_last);
  end
  // parse counters are cleared whenever no frame is being parsed
  always_ff @(posedge clk) begin
    if (rst || (state == PARSE && rx_frame_done) || !(state == IDLE || state == PARSE)) begin
      sub <= '0;
      idx <= '0;
      sr <= '0;
      bc <= 1'b1;
      uc <= 1'b1;
    end else if (rx_on) begin
      sr <= bv;
      sub <= done ? '0 : sub + 1'b1;
      if (done) begin
        idx <= idx == 6'd63 ? idx : idx + 6'd1;
        if (idx < 6'd6) begin
          bc <= nbc;
          uc <= nuc;
        end
        if (idx >= 6'd22 && idx <= 6'd27) req_sha <= {req_sha[39:0], bv};
        if (idx >= 6'd28 && idx <= 6'd31) req_spa <= {req_spa[23:0], bv};
      end
    end
  end
endmodule

// File: tb/tb_arp_responder.sv
// tb_arp_responder: randomized ARP requests, byte-level reference model, beat scoreboard
module tb_arp_responder;
  localparam int N = 2;
  localparam int BPB = 8 / N;
  localparam logic [31:0] MY_IP = 32'h12126b0d;
  localparam logic [47:0] MAC = 48'h69695A065491;
  logic clk, rst, rx_axiiv, rx_frame_done, rx_fcs_ok, tx_req, tx_grant, tx_axiov, tx_last;
  logic [47:0] mac;
  logic [N-1:0] rx_axiid, tx_axiod;
  logic [15:0] replies_sent;
  int total = 0, bad = 0, exp_replies = 0, beat_no = 0;
  logic [N:0] exp_q[$];
  logic [N:0] mon_e;
  bit busy = 0, prev_grant = 0;

  arp_responder #(.N(N), .MY_IP(MY_IP)) dut (
    .clk(clk), .rst(rst), .mac(mac), .rx_axiiv(rx_axiiv), .rx_axiid(rx_axiid),
    .rx_frame_done(rx_frame_done), .rx_fcs_ok(rx_fcs_ok), .tx_req(tx_req), .tx_grant(tx_grant),
    .tx_axiov(tx_axiov), .tx_axiod(tx_axiod), .tx_last(tx_last), .replies_sent(replies_sent)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void build_req(output logic [7:0] f[$], input logic [47:0] dst, sha,
                                    input logic [31:0] spa, tpa, input logic [15:0] etype, oper);
    f = {};
    for (int i = 0; i < 6; i++) f.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(sha[47-8*i -: 8]);
    f.push_back(etype[15:8]); f.push_back(etype[7:0]);
    f.push_back(8'h00); f.push_back(8'h01); f.push_back(8'h08); f.push_back(8'h00);
    f.push_back(8'h06); f.push_back(8'h04);
    f.push_back(oper[15:8]); f.push_back(oper[7:0]);
    for (int i = 0; i < 6; i++) f.push_back(sha[47-8*i -: 8]);
    for (int i = 0; i < 4; i++) f.push_back(spa[31-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(8'h00);
    for (int i = 0; i < 4; i++) f.push_back(tpa[31-8*i -: 8]);
    for (int i = 0; i < 18; i++) f.push_back(8'h00);
  endfunction

  function automatic bit accepts(input logic [7:0] f[$], input bit fcs);
    logic [7:0] want[10] = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01};
    logic [47:0] m = MAC;
    logic [31:0] ip = MY_IP;
    bit b = 1, u = 1;
    if (!fcs || f.size() < 42) return 0;
    for (int i = 0; i < 6; i++) begin
      b &= f[i] == 8'hff;
      u &= f[i] == m[47-8*i -: 8];
    end
    if (!(b || u)) return 0;
    for (int i = 0; i < 10; i++) if (f[12+i] != want[i]) return 0;
    for (int i = 0; i < 4; i++) if (f[38+i] != ip[31-8*i -: 8]) return 0;
    return 1;
  endfunction

  task automatic push_reply(input logic [7:0] f[$]);
    logic [7:0] r[$];
    logic [47:0] m = MAC;
    logic [31:0] ip = MY_IP;
    for (int i = 0; i < 6; i++) r.push_back(f[22+i]);
    for (int i = 0; i < 6; i++) r.push_back(m[47-8*i -: 8]);
    r = {r, 8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02};
    for (int i = 0; i < 6; i++) r.push_back(m[47-8*i -: 8]);
    for (int i = 0; i < 4; i++) r.push_back(ip[31-8*i -: 8]);
    for (int i = 0; i < 6; i++) r.push_back(f[22+i]);
    for (int i = 0; i < 4; i++) r.push_back(f[28+i]);
    for (int i = 0; i < 18; i++) r.push_back(8'h00);
    for (int j = 0; j < 60; j++)
      for (int k = 0; k < BPB; k++)
        exp_q.push_back({j == 59 && k == BPB - 1, N'(r[j] >> (8 - N * (k + 1)))});
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit fcs, input string name);
    bit was_busy = busy;
    bit acc;
    for (int j = 0; j < f.size(); j++)
      for (int k = 0; k < BPB; k++) begin
        rx_axiiv = 1;
        rx_axiid = N'(f[j] >> (8 - N * (k + 1)));
        step();
      end
    rx_axiiv = 0;
    rx_axiid = '0;
    rx_frame_done = 1;
    rx_fcs_ok = fcs;
    acc = !was_busy && accepts(f, fcs);
    if (acc) begin
      push_reply(f);
      busy = 1;
    end
    step();
    rx_frame_done = 0;
    rx_fcs_ok = 0;
    @(negedge clk);
    chk({name, " tx_req"}, tx_req, was_busy ? 1'b1 : acc);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({name, " reply finished"}, busy, 0);
    repeat (3) step();
    chk({name, " replies_sent"}, replies_sent, exp_replies);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_grant) chk("grant latency {axiov,req}", {tx_axiov, tx_req}, 2'b10);
      if (tx_axiov) begin
        beat_no++;
        if (exp_q.size() == 0) chk("unexpected tx beat", tx_axiov, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk($sformatf("beat %0d {last,data}", beat_no), {tx_last, tx_axiod}, mon_e);
          if (mon_e[N]) begin
            busy = 0;
            exp_replies++;
            beat_no = 0;
          end
        end
      end
    end
    prev_grant = tx_req && tx_grant && !rst;
  end

  logic [7:0] f[$], f2[$];
  logic [47:0] sha;
  logic [31:0] spa;

  initial begin
    rst = 1; mac = MAC; rx_axiiv = 0; rx_axiid = '0; rx_frame_done = 0; rx_fcs_ok = 0; tx_grant = 1;
    repeat (3) step();
    @(negedge clk);
    chk("reset tx_req", tx_req, 0);
    chk("reset tx_axiov", tx_axiov, 0);
    chk("reset tx_axiod", tx_axiod, 0);
    chk("reset tx_last", tx_last, 0);
    chk("reset replies_sent", replies_sent, 0);
    step();
    rst = 0;
    step();

    build_req(f, '1, 48'h001122334455, 32'hC0A80002, MY_IP, 16'h0806, 16'h0001);
    send_frame(f, 1, "broadcast");
    wait_idle("broadcast");
    build_req(f, '1, 48'h001122334455, 32'hC0A80002, 32'h12126B0E, 16'h0806, 16'h0001);
    send_frame(f, 1, "wrong tpa");
    wait_idle("wrong tpa");
    build_req(f, '1, 48'h001122334455, 32'hC0A80002, MY_IP, 16'h0806, 16'h0002);
    send_frame(f, 1, "oper reply");
    wait_idle("oper reply");
    build_req(f, '1, 48'h001122334455, 32'hC0A80002, MY_IP, 16'h0800, 16'h0001);
    send_frame(f, 1, "ethertype ip");
    wait_idle("ethertype ip");
    build_req(f, '1, 48'h0A0B0C0D0E0F, 32'hC0A80003, MY_IP, 16'h0806, 16'h0001);
    send_frame(f, 0, "bad fcs");
    wait_idle("bad fcs");
    f = f[0:29];
    send_frame(f, 1, "truncated 30");
    wait_idle("truncated 30");
    build_req(f, MAC, 48'hA1A2A3A4A5A6, 32'h0A000001, MY_IP, 16'h0806, 16'h0001);
    send_frame(f, 1, "unicast mine");
    wait_idle("unicast mine");
    build_req(f, 48'h000000000001, 48'hA1A2A3A4A5A6, 32'h0A000001, MY_IP, 16'h0806, 16'h0001);
    send_frame(f, 1, "unicast other");
    wait_idle("unicast other");
    build_req(f, '1, 48'hB0B1B2B3B4B5, 32'h0A000002, MY_IP, 16'h0806, 16'h0001);
    for (int i = 0; i < 10; i++) f.push_back(8'($urandom));
    send_frame(f, 1, "long frame");
    wait_idle("long frame");

    tx_grant = 0;
    build_req(f, '1, 48'hC0C1C2C3C4C5, 32'h0A000010, MY_IP, 16'h0806, 16'h0001);
    send_frame(f, 1, "held first");
    build_req(f2, '1, 48'hD0D1D2D3D4D5, 32'h0A000020, MY_IP, 16'h0806, 16'h0001);
    send_frame(f2, 1, "held second");
    repeat (20) step();
    @(negedge clk);
    chk("held tx_req", tx_req, 1);
    chk("held tx_axiov", tx_axiov, 0);
    step();
    tx_grant = 1;
    wait_idle("held");
    chk("held queue drained", exp_q.size(), 0);

    build_req(f, '1, 48'hE0E1E2E3E4E5, 32'h0A000030, MY_IP, 16'h0806, 16'h0001);
    send_frame(f, 1, "reset victim");
    for (int n = 0; beat_no < 100 && n < 1000; n++) @(negedge clk);
    chk("reached beat 100", beat_no >= 100, 1);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    exp_q = {};
    busy = 0;
    beat_no = 0;
    exp_replies = 0;
    @(negedge clk);
    chk("after reset tx_axiov", tx_axiov, 0);
    chk("after reset replies_sent", replies_sent, 0);
    step();
    build_req(f, '1, 48'hF0F1F2F3F4F5, 32'h0A000040, MY_IP, 16'h0806, 16'h0001);
    send_frame(f, 1, "after reset");
    wait_idle("after reset");

    for (int it = 0; it < 16; it++) begin
      int kind = $urandom_range(0, 7);
      bit fcs = kind != 5;
      sha = {16'($urandom), $urandom};
      spa = $urandom;
      build_req(f, kind == 1 ? MAC : (kind == 7 ? {16'($urandom), $urandom} : '1), sha, spa,
                kind == 2 ? MY_IP ^ (32'h1 << $urandom_range(0, 31)) : MY_IP,
                kind == 4 ? 16'h0800 : 16'h0806, kind == 3 ? 16'h0002 : 16'h0001);
      if (kind == 6) f = f[0:$urandom_range(20, 41)];
      send_frame(f, fcs, $sformatf("random %0d kind %0d", it, kind));
      wait_idle($sformatf("random %0d", it));
    end

    chk("final queue empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
